// File: rtl/spi_scan_ctl_pkg.sv
// Shared types and elaboration helpers for the SPI ADC scan sequencer.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        WAIT,
        GAP
    } scan_state_t;

    localparam int MAX_CHANNELS = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/spi_scan_ctl_if.sv
// Request/response bus between the scan sequencer and the SPI frame engine.
interface spi_scan_ctl_if #(
    parameter int ADC_WIDTH  = 8,
    parameter int CHAN_WIDTH = 5
);
    logic                  frm_req;
    logic                  frm_ack;
    logic [CHAN_WIDTH-1:0] frm_chan;
    logic                  frm_done;
    logic [ADC_WIDTH-1:0]  frm_data;

    modport master (
        output frm_req,
        output frm_chan,
        input  frm_ack,
        input  frm_done,
        input  frm_data
    );

    modport slave (
        input  frm_req,
        input  frm_chan,
        output frm_ack,
        output frm_done,
        output frm_data
    );
endinterface

// File: rtl/spi_scan_ctl_next_chan.sv
// Find-first-set over the latched channel mask, restricted to indices >= cur.
module spi_next_chan
    import spi_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_WIDTH   = 5
) (
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [CHAN_WIDTH:0]     cur,
    output logic                    found,
    output logic [CHAN_WIDTH-1:0]   idx
);

    // Scan downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && ((CHAN_WIDTH + 1)'(i) >= cur)) begin
                found = 1'b1;
                idx   = CHAN_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/spi_scan_ctl.sv
// Scan sequencer: walks the enabled-channel mask, requests one SPI frame per
// channel, stores returned samples in a result bank and guards each frame with a watchdog.
module spi_scan_ctl
    import spi_pkg::*;
#(
    parameter int ADC_WIDTH    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_WIDTH   = 5,
    parameter int SCAN_GAP     = 16,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    continuous,
    input  logic [NUM_CHANNELS-1:0] chan_mask,
    spi_scan_ctl_if.master          frm,
    input  logic [CHAN_WIDTH-1:0]   rd_chan,
    output logic [ADC_WIDTH-1:0]    rd_data,
    output logic [NUM_CHANNELS-1:0] ch_valid,
    output logic                    busy,
    output logic                    scan_done,
    output logic                    err_timeout
);

    localparam int WD_W  = clog2(TIMEOUT + 1);
    // The gap counter runs 0..SCAN_GAP, so SCAN_GAP=0 still needs one bit.
    localparam int GAP_W = clog2(SCAN_GAP + 2);

    scan_state_t             state;
    scan_state_t             state_nxt;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [CHAN_WIDTH:0]     cur_q;
    logic [CHAN_WIDTH-1:0]   chan_q;
    logic [WD_W-1:0]         wdog_q;
    logic [GAP_W-1:0]        gap_q;
    logic [ADC_WIDTH-1:0]    bank [NUM_CHANNELS];
    logic                    found;
    logic [CHAN_WIDTH-1:0]   next_idx;
    logic                    wd_expire;
    logic                    gap_end;

    spi_next_chan #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CHAN_WIDTH   (CHAN_WIDTH)
    ) u_next_chan (
        .mask  (mask_q),
        .cur   (cur_q),
        .found (found),
        .idx   (next_idx)
    );

    assign wd_expire = (wdog_q == WD_W'(TIMEOUT - 1));
    assign gap_end   = (gap_q == GAP_W'(SCAN_GAP));

    always_ff @(posedge clk) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SELECT;
            SELECT: begin
                if (found)            state_nxt = REQ;
                else if (!continuous) state_nxt = IDLE;
            end
            REQ:     if (frm.frm_ack) state_nxt = WAIT;
            WAIT:    if (frm.frm_done || wd_expire) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = SELECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frm.frm_req  = (state == REQ);
        frm.frm_chan = chan_q;
        busy         = (state != IDLE);
    end

    // Sequencer datapath: mask/cursor, watchdog, gap timer, result bank.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            mask_q      <= '0;
            cur_q       <= '0;
            chan_q      <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
            scan_done   <= 1'b0;
            err_timeout <= 1'b0;
            ch_valid    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) bank[i] <= '0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q      <= chan_mask;
                        cur_q       <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                SELECT: begin
                    if (found) begin
                        chan_q <= next_idx;
                    end else begin
                        scan_done <= 1'b1;
                        if (continuous) begin
                            mask_q <= chan_mask;
                            cur_q  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (frm.frm_ack) wdog_q <= '0;
                end
                WAIT: begin
                    if (wdog_q != WD_W'(TIMEOUT)) wdog_q <= wdog_q + WD_W'(1);
                    gap_q <= '0;
                    // A sample arriving on the expiry cycle wins over the timeout.
                    if (frm.frm_done) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (chan_q == CHAN_WIDTH'(i)) begin
                                bank[i]     <= frm.frm_data;
                                ch_valid[i] <= 1'b1;
                            end
                        end
                        cur_q <= {1'b0, chan_q} + (CHAN_WIDTH + 1)'(1);
                    end else if (wd_expire) begin
                        err_timeout <= 1'b1;
                        cur_q       <= {1'b0, chan_q} + (CHAN_WIDTH + 1)'(1);
                    end
                end
                GAP: begin
                    if (!gap_end) gap_q <= gap_q + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered bank read; out-of-range addresses read as zero.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (rd_chan == CHAN_WIDTH'(i)) rd_data <= bank[i];
            end
        end
    end

endmodule

// File: tb/tb_spi_scan_ctl.sv
// Directed bench for spi_scan_ctl with a frame-engine responder and a transaction-level result model.
`timescale 1ns/1ps
module tb_spi_scan_ctl;

    localparam int ADC_WIDTH    = 8;
    localparam int NUM_CHANNELS = 4;
    localparam int CHAN_WIDTH   = 5;
    localparam int SCAN_GAP     = 16;
    localparam int TIMEOUT      = 32;

    logic                    clk = 1'b0;
    logic                    n_rst = 1'b0;
    logic                    start = 1'b0;
    logic                    continuous = 1'b0;
    logic [NUM_CHANNELS-1:0] chan_mask = '0;
    logic [CHAN_WIDTH-1:0]   rd_chan = '0;
    logic [ADC_WIDTH-1:0]    rd_data;
    logic [NUM_CHANNELS-1:0] ch_valid;
    logic                    busy;
    logic                    scan_done;
    logic                    err_timeout;

    int checks = 0;
    int errors = 0;

    spi_scan_ctl_if #(.ADC_WIDTH(ADC_WIDTH), .CHAN_WIDTH(CHAN_WIDTH)) bus ();

    spi_scan_ctl #(
        .ADC_WIDTH    (ADC_WIDTH),
        .NUM_CHANNELS (NUM_CHANNELS),
        .CHAN_WIDTH   (CHAN_WIDTH),
        .SCAN_GAP     (SCAN_GAP),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .continuous  (continuous),
        .chan_mask   (chan_mask),
        .frm         (bus),
        .rd_chan     (rd_chan),
        .rd_data     (rd_data),
        .ch_valid    (ch_valid),
        .busy        (busy),
        .scan_done   (scan_done),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame engine: ack one cycle after seeing frm_req, return A0+chan ten cycles after the ack.
    int drop_ch = -1;
    initial begin : engine
        int ack_wait;
        int done_cnt;
        logic [CHAN_WIDTH-1:0] done_ch;
        ack_wait = 0;
        done_cnt = 0;
        done_ch  = '0;
        bus.frm_ack  = 1'b0;
        bus.frm_done = 1'b0;
        bus.frm_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.frm_ack  = 1'b0;
            bus.frm_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0 && int'(done_ch) != drop_ch) begin
                    bus.frm_done = 1'b1;
                    bus.frm_data = 8'hA0 + 8'(done_ch);
                end
            end
            if (bus.frm_req) begin
                if (ack_wait == 0) begin
                    ack_wait = 1;
                end else begin
                    bus.frm_ack = 1'b1;
                    done_ch     = bus.frm_chan;
                    done_cnt    = 10;
                    ack_wait    = 0;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    // Result model: what the bank, valid bits, error flag and read port must hold.
    logic [ADC_WIDTH-1:0]    mb [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] mvalid = '0;
    logic                    merr = 1'b0;
    logic [ADC_WIDTH-1:0]    exp_rd = '0;
    bit  run_chk = 0, frame_live = 0, clr_err_req = 0, have_done = 0;
    bit  prev_req = 0, prev_sd = 0;
    logic [CHAN_WIDTH-1:0] prev_chan = '0;
    int  live_ch = 0, ack_edge = 0, done_edge = 0, last_spacing = -1, sd_cnt = 0;
    int  exp_chans[$];

    initial begin : compare
        logic [ADC_WIDTH-1:0] next_rd;
        for (int i = 0; i < NUM_CHANNELS; i++) mb[i] = '0;
        forever begin
            @(negedge clk);
            if (run_chk) begin
                chk("ch_valid", ch_valid, mvalid);
                chk("rd_data", rd_data, exp_rd);
                chk("err_timeout", err_timeout, merr);
                chk("scan_done_width", {31'b0, scan_done && prev_sd}, 0);
                if (scan_done) sd_cnt++;
                if (bus.frm_req && !prev_req) begin
                    if (exp_chans.size() == 0) chk("frm_req_unexpected", bus.frm_req, 0);
                    else chk("frm_chan_order", bus.frm_chan, exp_chans.pop_front());
                    if (have_done) last_spacing = cyc - done_edge;
                end
                if (bus.frm_req && prev_req) chk("frm_chan_stable", bus.frm_chan, prev_chan);

                next_rd = (int'(rd_chan) < NUM_CHANNELS) ? mb[int'(rd_chan)] : '0;
                if (!n_rst) begin
                    for (int i = 0; i < NUM_CHANNELS; i++) mb[i] = '0;
                    mvalid     = '0;
                    merr       = 1'b0;
                    next_rd    = '0;
                    frame_live = 0;
                    have_done  = 0;
                end else begin
                    if (start && clr_err_req) begin
                        merr        = 1'b0;
                        clr_err_req = 0;
                    end
                    if (bus.frm_req && bus.frm_ack) begin
                        frame_live = 1;
                        live_ch    = int'(bus.frm_chan);
                        ack_edge   = cyc + 1;
                    end else if (frame_live && bus.frm_done) begin
                        mb[live_ch]     = bus.frm_data;
                        mvalid[live_ch] = 1'b1;
                        frame_live      = 0;
                        done_edge       = cyc + 1;
                        have_done       = 1;
                    end else if (frame_live && (cyc + 1 - ack_edge) == TIMEOUT) begin
                        merr       = 1'b1;
                        frame_live = 0;
                        have_done  = 0;
                    end
                end
                exp_rd = next_rd;
            end
            prev_req  = bus.frm_req;
            prev_chan = bus.frm_chan;
            prev_sd   = scan_done;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 n_rst = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("rst_frm_req", bus.frm_req, 0);
        chk("rst_frm_chan", bus.frm_chan, 0);
        chk("rst_busy", busy, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_ch_valid", ch_valid, 0);
        chk("rst_rd_data", rd_data, 0);
    endtask

    task automatic push_scan(input logic [NUM_CHANNELS-1:0] m);
        for (int i = 0; i < NUM_CHANNELS; i++) if (m[i]) exp_chans.push_back(i);
    endtask

    task automatic pulse_start(input logic [NUM_CHANNELS-1:0] m, input logic cont);
        @(posedge clk);
        #1;
        chan_mask   = m;
        continuous  = cont;
        start       = 1'b1;
        clr_err_req = 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk(name, busy, 0);
    endtask

    task automatic read_chk(input int c, input logic [ADC_WIDTH-1:0] exp);
        @(posedge clk);
        #1 rd_chan = CHAN_WIDTH'(c);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("read_ch%0d", c), rd_data, exp);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int base;
        int n;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        run_chk = 1;
        do_reset();

        // Full mask, single shot.
        push_scan(4'b1111);
        pulse_start(4'b1111, 1'b0);
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_req_low", bus.frm_req, 0);
        @(negedge clk);
        chk("start_req_high", bus.frm_req, 1);
        wait_idle(1000, "full_idle");
        chk("full_scans", sd_cnt, 1);
        chk("full_ch_valid", ch_valid, 4'b1111);
        chk("full_queue_empty", exp_chans.size(), 0);
        read_chk(0, 8'hA0);
        read_chk(1, 8'hA1);
        read_chk(2, 8'hA2);
        read_chk(3, 8'hA3);

        // Sparse mask after reset.
        do_reset();
        push_scan(4'b1010);
        pulse_start(4'b1010, 1'b0);
        wait_idle(1000, "sparse_idle");
        chk("sparse_ch_valid", ch_valid, 4'b1010);
        chk("sparse_queue_empty", exp_chans.size(), 0);
        read_chk(0, 8'h00);
        read_chk(1, 8'hA1);
        read_chk(3, 8'hA3);
        read_chk(6, 8'h00);

        // Zero mask: scan_done two cycles after start, no frames.
        base = sd_cnt;
        pulse_start(4'b0000, 1'b0);
        @(negedge clk);
        chk("zero_sd_early", scan_done, 0);
        chk("zero_busy_early", busy, 1);
        @(negedge clk);
        chk("zero_sd", scan_done, 1);
        chk("zero_busy_fall", busy, 0);
        repeat (3) @(negedge clk);
        #1 chk("zero_sd_count", sd_cnt - base, 1);

        // Engine stalls on channel 2.
        do_reset();
        drop_ch = 2;
        push_scan(4'b1111);
        pulse_start(4'b1111, 1'b0);
        wait_idle(2000, "timeout_idle");
        chk("timeout_err", err_timeout, 1);
        chk("timeout_ch_valid", ch_valid, 4'b1011);
        chk("timeout_queue_empty", exp_chans.size(), 0);
        drop_ch = -1;
        push_scan(4'b0001);
        pulse_start(4'b0001, 1'b0);
        @(negedge clk);
        chk("restart_clears_err", err_timeout, 0);
        wait_idle(1000, "restart_idle");

        // Continuous: three full scans, drop continuous during the fourth.
        base = sd_cnt;
        for (int s = 0; s < 4; s++) push_scan(4'b0101);
        pulse_start(4'b0101, 1'b1);
        n = 0;
        while (sd_cnt < base + 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1 chk("cont_three_scans", sd_cnt - base, 3);
        repeat (3) @(negedge clk);
        continuous = 1'b0;
        chan_mask  = 4'b1111;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(3000, "cont_idle");
        chk("cont_scan_count", sd_cnt - base, 4);
        chk("cont_queue_empty", exp_chans.size(), 0);
        chk("gap_spacing", last_spacing, SCAN_GAP + 2);

        // Reset in the middle of a frame; the late frm_done must be dropped.
        do_reset();
        push_scan(4'b0001);
        pulse_start(4'b0001, 1'b0);
        n = 0;
        while (!(frame_live && (cyc - ack_edge) >= 3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midwait_reached", {31'b0, frame_live}, 1);
        do_reset();
        repeat (20) @(negedge clk);
        chk("midwait_no_store", ch_valid, 4'b0000);
        chk("midwait_busy", busy, 0);
        chk("midwait_req", bus.frm_req, 0);
        read_chk(0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
